// File: rtl/unreg_shift_sequencer.sv
// unreg_shift_sequencer: sequencing controller for the 16-bit load/shift register.
// Accepts NOP/LOAD/SHIFT/LOAD_SHIFT commands over valid/ready, owns the shift
// register, serialises it MSB-first under backpressure and drives the datapath
// mode controls (s, t, u).
module unreg_shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             mode_s,
    output logic             mode_t,
    output logic             mode_u,
    output logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_NOP        = 2'b00;
    localparam logic [1:0] OP_LOAD       = 2'b01;
    localparam logic [1:0] OP_SHIFT      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_shift;
    logic             r_cmd_ready;
    logic             r_ser_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             w_shift_fire;

    // Command handshake and shift count clamped to the register width
    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_cnt_sat    = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;
    assign w_shift_fire = (r_state == ST_SHIFT) && ser_ready;

    // Sequencer: state, shift register, counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_reg       <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_op_shift  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_NOP: begin
                                r_done <= 1'b1;
                            end
                            OP_LOAD, OP_LOAD_SHIFT: begin
                                r_data      <= cmd_data;
                                r_op_shift  <= (cmd_op == OP_LOAD_SHIFT);
                                if (cmd_op == OP_LOAD_SHIFT) begin
                                    r_cnt <= w_cnt_sat;
                                end
                                r_state     <= ST_LOAD;
                                r_cmd_ready <= 1'b0;
                                r_busy      <= 1'b1;
                            end
                            OP_SHIFT: begin
                                r_cnt       <= w_cnt_sat;
                                r_cmd_ready <= 1'b0;
                                r_busy      <= 1'b1;
                                if (w_cnt_sat == '0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state     <= ST_SHIFT;
                                    r_ser_valid <= 1'b1;
                                end
                            end
                            default: begin
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    // The captured value lands in the register on the edge leaving LOAD
                    r_reg <= r_data;
                    if (!r_op_shift) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_SHIFT;
                        r_ser_valid <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        r_reg <= {r_reg[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= ST_DONE;
                            r_ser_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_ser_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Mode controls qualify the same edge as the serial handshake, so they
    // are decoded from the state register and ser_ready; load and shift are
    // mutually exclusive because they come from different states.
    assign mode_s = 1'b0;
    assign mode_t = w_shift_fire;
    assign mode_u = (r_state == ST_LOAD) || w_shift_fire;

    assign cmd_ready = r_cmd_ready;
    assign ser_valid = r_ser_valid;
    assign ser_out   = r_reg[WIDTH-1];
    assign reg_q     = r_reg;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_unreg_shift_sequencer.sv
// Bench for unreg_shift_sequencer: directed and random commands checked against
// a transaction-level model (expected bit queue, final register, done timing).
module tb_unreg_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [4:0]  cmd_cnt;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_ready;
    logic        mode_s;
    logic        mode_t;
    logic        mode_u;
    logic [15:0] reg_q;
    logic        busy;
    logic        done;

    int          errors;
    int          checks;
    logic [15:0] m_reg;

    unreg_shift_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .mode_s    (mode_s),
        .mode_t    (mode_t),
        .mode_u    (mode_u),
        .reg_q     (reg_q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command from an IDLE negedge until the controller is ready again.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input logic [4:0] cnt,
                           input bit rnd_rdy, input logic [31:0] rdy_pat, input bit hold);
        bit          has_load;
        bit          has_shift;
        int          n;
        logic [15:0] base;
        logic [15:0] fin;
        bit          exp_q[$];
        int          k;
        int          vcnt;
        int          ndone;
        int          done_k;
        int          last_acc;
        int          exp_done_k;
        bit          stall;
        logic [15:0] st_reg;
        logic        st_bit;
        has_load  = op[0];
        has_shift = op[1];
        n         = has_shift ? ((int'(cnt) > 16) ? 16 : int'(cnt)) : 0;
        base      = has_load ? data : m_reg;
        fin       = base << n;
        for (int i = 0; i < n; i++) exp_q.push_back(base[15-i]);
        k = 0; vcnt = 0; ndone = 0; done_k = -1; last_acc = -1; stall = 0;
        st_reg = '0; st_bit = 1'b0;

        chk("accept_ready", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        ser_ready = 1'($urandom_range(0, 1));
        #1;
        chk("idle_mode_hold", 32'({mode_s, mode_t, mode_u}), 32'(0));

        forever begin
            @(negedge clk);
            k++;
            if (k > 300) begin
                checks++;
                errors++;
                $error("FAIL timeout op=%0d cycles=%0d limit=300", op, k);
                break;
            end
            if (k == 1) begin
                chk("busy_after_accept", 32'(busy), 32'(op != 2'b00));
                chk("ready_after_accept", 32'(cmd_ready), 32'(op == 2'b00));
                if (has_load) chk("reg_before_load", 32'(reg_q), 32'(m_reg));
            end
            if (stall) begin
                chk("stall_reg", 32'(reg_q), 32'(st_reg));
                chk("stall_bit", 32'(ser_out), 32'(st_bit));
                stall = 0;
            end
            if (done) begin
                ndone++;
                done_k = k;
                chk("done_reg", 32'(reg_q), 32'(fin));
            end
            if (cmd_ready) break;

            if (rnd_rdy) ser_ready = ($urandom_range(0, 99) < 60);
            else if (ser_valid && vcnt < 32) ser_ready = rdy_pat[vcnt];
            else ser_ready = 1'b1;
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_data  = 16'hDEAD;
                cmd_cnt   = 5'($urandom_range(0, 31));
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            chk("mode_s_zero", 32'(mode_s), 32'(0));
            chk("mode_shift", 32'(mode_t), 32'(ser_valid && ser_ready));
            chk("mode_u", 32'(mode_u), 32'((k == 1 && has_load) || (ser_valid && ser_ready)));
            if (ser_valid) begin
                vcnt++;
                chk("valid_only_when_bits_pending", 32'(ser_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    if (vcnt == 1) chk("first_valid_cycle", 32'(k), 32'(has_load ? 2 : 1));
                    chk("ser_bit", 32'(ser_out), 32'(exp_q[0]));
                    if (ser_ready) begin
                        void'(exp_q.pop_front());
                        last_acc = k;
                    end else begin
                        stall  = 1;
                        st_reg = reg_q;
                        st_bit = ser_out;
                    end
                end
            end
        end

        exp_done_k = (n > 0) ? last_acc + 1 : (has_load ? 2 : 1);
        chk("done_count", 32'(ndone), 32'(1));
        chk("bits_left", 32'(exp_q.size()), 32'(0));
        chk("done_cycle", 32'(done_k), 32'(exp_done_k));
        chk("final_reg", 32'(reg_q), 32'(fin));
        m_reg     = fin;
        cmd_valid = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        m_reg     = '0;
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_cnt   = '0;
        ser_ready = 1'b0;

        // Reset values
        #2;
        chk("rst_ready", 32'(cmd_ready), 32'(1));
        chk("rst_valid", 32'(ser_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_reg", 32'(reg_q), 32'(0));
        chk("rst_modes", 32'({mode_s, mode_t, mode_u}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // LOAD, LOAD_SHIFT cnt 8, SHIFT with stalls, SHIFT 0, SHIFT 31
        run_cmd(2'b01, 16'hA5C3, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b11, 16'hA5C3, 5'd8, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b01, 16'hF000, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b10, 16'h0000, 5'd4, 1'b0, 32'hFFFF_FFD9, 1'b0);
        run_cmd(2'b00, 16'h0000, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b10, 16'h0000, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b01, 16'h1234, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b10, 16'h0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b11, 16'hBEEF, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Reset during the 5th bit of a 16-bit shift
        run_cmd(2'b01, 16'hFFFF, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = 5'd16;
        ser_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("pre_rst_reg", 32'(reg_q), 32'(16'hFFF0));
        chk("pre_rst_valid", 32'(ser_valid), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("midrst_reg", 32'(reg_q), 32'(0));
        chk("midrst_valid", 32'(ser_valid), 32'(0));
        chk("midrst_ready", 32'(cmd_ready), 32'(1));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_modes", 32'({mode_s, mode_t, mode_u}), 32'(0));
        @(negedge clk);
        rst   = 1'b0;
        m_reg = '0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_done", 32'(done), 32'(0));
            chk("postrst_ready", 32'(cmd_ready), 32'(1));
        end

        // Back-to-back commands with cmd_valid held high while busy
        run_cmd(2'b11, 16'h8421, 5'd5, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_cmd(2'b01, 16'h5A5A, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_cmd(2'b00, 16'h0000, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_cmd(2'b10, 16'h0000, 5'd20, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_cmd(2'b10, 16'h0000, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Random commands, random backpressure
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 16'($urandom), 5'($urandom_range(0, 31)),
                    1'b1, 32'hFFFF_FFFF, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
